// File: rtl/diff_mon_pkg.sv
// diff_mon_pkg: state encoding and counter widths for the differential input monitor.
package diff_mon_pkg;
  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;
  localparam int LOCK_W  = 8;
  localparam int FAULT_W = 8;
  localparam int IDLE_W  = 16;
  localparam int ERR_W   = 16;
endpackage

// File: rtl/diff_input_monitor_sync2.sv
// sync2: two-flop synchronizer with a selectable reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) {q, m} <= {2{RST_VAL}};
    else        {q, m} <= {m, d};
endmodule

// File: rtl/diff_input_monitor.sv
// diff_input_monitor: qualifies a differential pair, tracks lock/fault state and counts faults.
module diff_input_monitor
  import diff_mon_pkg::*;
#(
  parameter int LOCK_CNT  = 8,
  parameter int FAULT_CNT = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             I,
  input  logic             IB,
  input  logic             RESTART,
  input  logic             ERR_CLR,
  output logic             O,
  output logic             INVALID,
  output logic             LOCKED,
  output logic             FAULT,
  output logic [ERR_W-1:0] ERR_CNT
);
  // Compare against count-1 so each counter tops out one below its parameter and cannot wrap.
  localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCK_CNT - 1);
  localparam logic [FAULT_W-1:0] FAULT_LAST = FAULT_W'(FAULT_CNT - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(TIMEOUT - 1);
  logic si, sib, valid, trans, to_fault;
  state_t state, state_nx;
  logic [LOCK_W-1:0]  lcnt, lcnt_nx;
  logic [FAULT_W-1:0] fcnt, fcnt_nx;
  logic [IDLE_W-1:0]  icnt, icnt_nx;
  logic [ERR_W-1:0]   err_nx;
  // Synchronizers idle at valid-0 so reset release does not look like an invalid sample.
  sync2 #(.RST_VAL(1'b0)) u_sync_i  (.CLK(CLK), .RST_N(RST_N), .d(I),  .q(si));
  sync2 #(.RST_VAL(1'b1)) u_sync_ib (.CLK(CLK), .RST_N(RST_N), .d(IB), .q(sib));
  assign valid    = si ^ sib;
  assign trans    = valid && (si != O);
  assign to_fault = (state == ST_LOCKED) &&
                    ((!valid && fcnt == FAULT_LAST) || (!trans && icnt == IDLE_LAST));
  assign LOCKED   = state == ST_LOCKED;
  assign FAULT    = state == ST_FAULT;
  always_comb begin
    state_nx = state;
    lcnt_nx  = '0;
    fcnt_nx  = '0;
    icnt_nx  = '0;
    if (RESTART) state_nx = ST_ACQ;
    else if (state == ST_ACQ) begin
      if (trans && lcnt == LOCK_LAST) state_nx = ST_LOCKED;
      else lcnt_nx = !valid ? '0 : trans ? lcnt + 1'b1 : lcnt;
    end else if (state == ST_LOCKED) begin
      if (to_fault) state_nx = ST_FAULT;
      else begin
        fcnt_nx = valid ? '0 : fcnt + 1'b1;
        icnt_nx = trans ? '0 : icnt + 1'b1;
      end
    end
  end
  assign err_nx = ERR_CLR ? '0 :
                  (to_fault && !RESTART && ERR_CNT != '1) ? ERR_CNT + 1'b1 : ERR_CNT;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state   <= ST_ACQ;
      lcnt    <= '0;
      fcnt    <= '0;
      icnt    <= '0;
      O       <= 1'b0;
      INVALID <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      state   <= state_nx;
      lcnt    <= lcnt_nx;
      fcnt    <= fcnt_nx;
      icnt    <= icnt_nx;
      O       <= valid ? si : O;
      INVALID <= !valid;
      ERR_CNT <= err_nx;
    end
endmodule

// File: tb/tb_diff_input_monitor.sv
// tb_diff_input_monitor: directed scenarios for lock, fault, timeout, restart and reset behaviour.
module tb_diff_input_monitor;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic I = 1'b0;
  logic IB = 1'b1;
  logic RESTART = 1'b0;
  logic ERR_CLR = 1'b0;
  logic O, INVALID, LOCKED, FAULT;
  logic [15:0] ERR_CNT;
  logic lvl = 1'b0;
  int checks = 0;
  int errors = 0;

  diff_input_monitor dut (
    .CLK(CLK), .RST_N(RST_N), .I(I), .IB(IB), .RESTART(RESTART), .ERR_CLR(ERR_CLR),
    .O(O), .INVALID(INVALID), .LOCKED(LOCKED), .FAULT(FAULT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_pair(input logic v);
    I = v;
    IB = ~v;
  endtask

  task automatic set_invalid();
    I = 1'b1;
    IB = 1'b1;
  endtask

  task automatic do_trans(input int n);
    for (int k = 0; k < n; k++) begin
      lvl = ~lvl;
      set_pair(lvl);
      step(4);
    end
  endtask

  task automatic pulse_restart();
    RESTART = 1'b1;
    step(1);
    RESTART = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    set_pair(1'b0);
    step(2);
    checks++;
    if ({O, INVALID, LOCKED, FAULT, ERR_CNT} !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs: got O=%b INV=%b LK=%b FT=%b ERR=%h expected all zero", O, INVALID, LOCKED, FAULT, ERR_CNT);
    end
    RST_N = 1'b1;
    step(4);
    checks++;
    if ({INVALID, LOCKED, FAULT} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_quiet: got INV=%b LK=%b FT=%b expected 000", INVALID, LOCKED, FAULT);
    end
  endtask

  task automatic test_lock();
    do_trans(7);
    checks++;
    if (LOCKED !== 1'b0 || O !== 1'b1) begin
      errors++;
      $display("FAIL lock_after7: got LK=%b O=%b expected LK=0 O=1", LOCKED, O);
    end
    lvl = ~lvl;
    set_pair(lvl);
    step(2);
    checks++;
    if (LOCKED !== 1'b0 || O !== 1'b1) begin
      errors++;
      $display("FAIL lock_latency_early: got LK=%b O=%b expected LK=0 O=1", LOCKED, O);
    end
    step(1);
    checks++;
    if (LOCKED !== 1'b1 || O !== 1'b0) begin
      errors++;
      $display("FAIL lock_after8: got LK=%b O=%b expected LK=1 O=0", LOCKED, O);
    end
    step(1);
  endtask

  task automatic test_invalid_short();
    int cnt = 0;
    set_invalid();
    for (int j = 0; j < 10; j++) begin
      step(1);
      cnt += int'(INVALID);
      if (j == 2) set_pair(lvl);
    end
    checks++;
    if (cnt !== 3) begin
      errors++;
      $display("FAIL invalid_pulse_len: got %0d expected 3", cnt);
    end
    checks++;
    if (LOCKED !== 1'b1 || FAULT !== 1'b0 || O !== lvl) begin
      errors++;
      $display("FAIL invalid_short_hold: got LK=%b FT=%b O=%b expected LK=1 FT=0 O=%b", LOCKED, FAULT, O, lvl);
    end
  endtask

  task automatic test_fault_invalid();
    set_invalid();
    step(5);
    checks++;
    if (FAULT !== 1'b0 || LOCKED !== 1'b1) begin
      errors++;
      $display("FAIL fault_early: got FT=%b LK=%b expected FT=0 LK=1", FAULT, LOCKED);
    end
    step(1);
    checks++;
    if (FAULT !== 1'b1 || LOCKED !== 1'b0 || ERR_CNT !== 16'd1) begin
      errors++;
      $display("FAIL fault_entry: got FT=%b LK=%b ERR=%0d expected FT=1 LK=0 ERR=1", FAULT, LOCKED, ERR_CNT);
    end
    set_pair(lvl);
    step(10);
    checks++;
    if (FAULT !== 1'b1) begin
      errors++;
      $display("FAIL fault_persist: got FT=%b expected 1", FAULT);
    end
    lvl = ~lvl;
    set_pair(lvl);
    step(3);
    checks++;
    if (O !== lvl || FAULT !== 1'b1 || ERR_CNT !== 16'd1) begin
      errors++;
      $display("FAIL o_track_in_fault: got O=%b FT=%b ERR=%0d expected O=%b FT=1 ERR=1", O, FAULT, ERR_CNT, lvl);
    end
  endtask

  task automatic test_timeout();
    pulse_restart();
    checks++;
    if (FAULT !== 1'b0 || LOCKED !== 1'b0) begin
      errors++;
      $display("FAIL restart_to_acq: got FT=%b LK=%b expected 0 0", FAULT, LOCKED);
    end
    do_trans(8);
    step(253);
    checks++;
    if (FAULT !== 1'b0 || LOCKED !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got FT=%b LK=%b expected FT=0 LK=1", FAULT, LOCKED);
    end
    step(1);
    checks++;
    if (FAULT !== 1'b1 || LOCKED !== 1'b0 || ERR_CNT !== 16'd2) begin
      errors++;
      $display("FAIL timeout_fault: got FT=%b LK=%b ERR=%0d expected FT=1 LK=0 ERR=2", FAULT, LOCKED, ERR_CNT);
    end
  endtask

  task automatic test_acq_restart();
    pulse_restart();
    do_trans(5);
    set_invalid();
    step(1);
    set_pair(lvl);
    step(4);
    do_trans(7);
    checks++;
    if (LOCKED !== 1'b0) begin
      errors++;
      $display("FAIL acq_invalid_clears: got LK=%b expected 0", LOCKED);
    end
    do_trans(1);
    checks++;
    if (LOCKED !== 1'b1) begin
      errors++;
      $display("FAIL acq_relock: got LK=%b expected 1", LOCKED);
    end
  endtask

  task automatic test_restart_wins();
    set_invalid();
    step(5);
    RESTART = 1'b1;
    step(1);
    RESTART = 1'b0;
    checks++;
    if (FAULT !== 1'b0 || LOCKED !== 1'b0 || ERR_CNT !== 16'd2) begin
      errors++;
      $display("FAIL restart_wins: got FT=%b LK=%b ERR=%0d expected FT=0 LK=0 ERR=2", FAULT, LOCKED, ERR_CNT);
    end
    set_pair(lvl);
    step(4);
  endtask

  task automatic test_saturate();
    do_trans(8);
    set_invalid();
    step(6);
    checks++;
    if (FAULT !== 1'b1 || ERR_CNT !== 16'd3) begin
      errors++;
      $display("FAIL third_fault: got FT=%b ERR=%0d expected FT=1 ERR=3", FAULT, ERR_CNT);
    end
    set_pair(lvl);
    step(3);
    force dut.ERR_CNT = 16'hFFFF;
    step(1);
    release dut.ERR_CNT;
    step(1);
    pulse_restart();
    do_trans(8);
    set_invalid();
    step(6);
    checks++;
    if (FAULT !== 1'b1 || ERR_CNT !== 16'hFFFF) begin
      errors++;
      $display("FAIL err_saturate: got FT=%b ERR=%h expected FT=1 ERR=ffff", FAULT, ERR_CNT);
    end
    set_pair(lvl);
    step(3);
    pulse_restart();
    do_trans(8);
    set_invalid();
    step(5);
    ERR_CLR = 1'b1;
    step(1);
    ERR_CLR = 1'b0;
    checks++;
    if (FAULT !== 1'b1 || ERR_CNT !== 16'd0) begin
      errors++;
      $display("FAIL clr_wins: got FT=%b ERR=%h expected FT=1 ERR=0000", FAULT, ERR_CNT);
    end
    set_pair(lvl);
    step(3);
  endtask

  task automatic test_async_reset();
    pulse_restart();
    do_trans(8);
    if (!lvl) do_trans(1);
    checks++;
    if (LOCKED !== 1'b1 || O !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_lock: got LK=%b O=%b expected LK=1 O=1", LOCKED, O);
    end
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({O, INVALID, LOCKED, FAULT, ERR_CNT} !== 20'd0) begin
      errors++;
      $display("FAIL async_reset: got O=%b INV=%b LK=%b FT=%b ERR=%h expected all zero", O, INVALID, LOCKED, FAULT, ERR_CNT);
    end
    lvl = 1'b0;
    set_pair(lvl);
    step(3);
    RST_N = 1'b1;
    step(4);
    do_trans(7);
    checks++;
    if (LOCKED !== 1'b0) begin
      errors++;
      $display("FAIL no_stale_lock: got LK=%b expected 0", LOCKED);
    end
    do_trans(1);
    checks++;
    if (LOCKED !== 1'b1) begin
      errors++;
      $display("FAIL relock_after_reset: got LK=%b expected 1", LOCKED);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_invalid_short();
    test_fault_invalid();
    test_timeout();
    test_acq_restart();
    test_restart_wins();
    test_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/diff_input_monitor.md
DIFF_INPUT_MONITOR -- requirements
Module: diff_input_monitor

Interface
REQ-001 Parameter LOCK_CNT, default 8, valid level transitions required to declare lock (range 1-255).
REQ-002 Parameter FAULT_CNT, default 4, consecutive invalid samples that break lock (range 1-255).
REQ-003 Parameter TIMEOUT, default 255, CLK cycles without a valid transition that break lock (range 1-65535).
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-006 I  input  1  positive leg of differential pair, asynchronous to CLK.
REQ-007 IB  input  1  negative leg of differential pair, asynchronous to CLK.
REQ-008 RESTART  input  1  synchronous single-cycle pulse; returns monitor to acquisition.
REQ-009 ERR_CLR  input  1  synchronous single-cycle pulse; clears ERR_CNT.
REQ-010 O  output  1  qualified data: last valid level of the pair, held through invalid samples.
REQ-011 INVALID  output  1  registered flag, current synchronized sample has I == IB.
REQ-012 LOCKED  output  1  high while state is LOCKED.
REQ-013 FAULT  output  1  high while state is FAULT.
REQ-014 ERR_CNT  output  16  count of FAULT entries, saturating.

Function
REQ-015 I and IB shall each pass through a 2-flop synchronizer; classification uses the second-stage values only.
REQ-016 Sample classification: (1,0) = valid-1, (0,1) = valid-0, (0,0) or (1,1) = invalid.
REQ-017 A pair stable before rising edge n shall appear on O/INVALID after edge n+2 (latency 3 edges, fixed).
REQ-018 On a valid sample O shall take the value of synchronized I; on an invalid sample O shall hold.
REQ-019 A valid transition is a valid sample whose level differs from the current O.
REQ-020 States: ACQ, LOCKED, FAULT; reset state ACQ.
REQ-021 ACQ: count valid transitions; any invalid sample clears the count; count reaching LOCK_CNT -> LOCKED next cycle, counters cleared.
REQ-022 LOCKED: count consecutive invalid samples (cleared by any valid sample); count reaching FAULT_CNT -> FAULT.
REQ-023 LOCKED: idle counter increments each cycle, cleared on valid transition; reaching TIMEOUT -> FAULT.
REQ-024 Entry to FAULT shall increment ERR_CNT by 1, saturating at 16'hFFFF.
REQ-025 FAULT shall persist until RESTART; RESTART in any state -> ACQ next cycle with all state counters cleared, ERR_CNT unchanged.
REQ-026 RESTART in the same cycle as a LOCKED->FAULT condition: RESTART wins, no FAULT entry, no ERR_CNT increment.
REQ-027 ERR_CLR coincident with an ERR_CNT increment: clear wins, ERR_CNT = 0.
REQ-028 O shall continue tracking valid samples in every state, including FAULT.
REQ-029 Internal counters shall be sized to hold their parameter maximum and shall never wrap.

Reset
REQ-030 RST_N low shall asynchronously force: state ACQ, O=0, INVALID=0, LOCKED=0, FAULT=0, ERR_CNT=0, all counters 0.
REQ-031 Synchronizer flops shall reset to I=0, IB=1 (valid-0) so no spurious invalid follows reset.
REQ-032 Reset deassertion mid-operation shall restart acquisition from zero; no stale lock may survive.

Structure
REQ-033 Package diff_mon_pkg shall hold the state enumeration and counter width constants.
REQ-034 One sub-module, sync2 (2-flop synchronizer, async active-low reset, reset value parameter), instantiated for I and IB.

Verification
REQ-035 Toggle pair every 4 cycles from reset, defaults -> LOCKED rises after 8th valid transition (+2 sync latency); O follows I.
REQ-036 Locked; drive I=IB=1 for 3 cycles then valid -> INVALID pulses 3 cycles, O holds, LOCKED stays 1; 4 cycles -> FAULT=1, ERR_CNT=1.
REQ-037 Locked; hold pair at valid-1 for 255 cycles -> FAULT asserts, LOCKED drops, ERR_CNT increments.
REQ-038 In ACQ after 5 transitions insert one invalid sample -> count restarts; lock needs 8 further transitions.
REQ-039 FAULT with ERR_CNT=16'hFFFF, force another fault after RESTART -> ERR_CNT stays 16'hFFFF; ERR_CLR same cycle -> 0.
REQ-040 Assert RST_N low mid-LOCKED between clock edges -> all outputs zero immediately, state ACQ.
